icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
//  Miss/refill sequencer for the fetch-stage instruction cache. Gates the fetch-ready signal, detects misses on FE_PC and
//  issues one line-read request per miss to the memory port. It then writes each returned word into the cache array,
//  validates the line, and raises an instruction access fault on a bus error. Sits between fetch, icache array and memory.
// PARAMETERS
//  LINE_WORDS  4   32-bit words per cache line (power of 2, >=2); OB = clog2(LINE_WORDS)+2 line-offset bits
//  CNT_W       32  width of saturating miss counter PERF_MISSES
// PORTS
//  CLK            in   1   clock, all state on rising edge
//  RESET          in   1   asynchronous, active-low reset
//  FE_PC          in   64  current fetch PC
//  FE_REQ         in   1   fetch wants an instruction this cycle
//  FE_FLUSH       in   1   redirect (branch/trap); abandons the current miss from fetch's point of view
//  IC_HIT         in   1   icache tag lookup hit for FE_PC (combinational from array)
//  FE_ICACHE_R    out  1   instruction at FE_PC valid this cycle
//  FE_IAF         out  1   instruction access fault, 1-cycle pulse
//  MEM_REQ        out  1   line read request, held until MEM_ACK
//  MEM_ADDR       out  64  line-aligned request address
//  MEM_ACK        in   1   request accepted
//  MEM_RVALID     in   1   one read beat (32-bit word) valid
//  MEM_RDATA      in   32  read beat data
//  MEM_ERR        in   1   beat carries bus error (qualified by MEM_RVALID)
//  IC_WE          out  1   write one word into icache data array
//  IC_WADDR       out  64  byte address of word being written
//  IC_WDATA       out  32  word being written (= MEM_RDATA)
//  IC_LINE_VALID  out  1   set tag+valid for line at MEM_ADDR, 1-cycle pulse
//  BUSY           out  1   state != IDLE
//  PERF_MISSES    out  CNT_W  miss count, saturates at all-ones
// BEHAVIOUR
//  Reset (RESET=0, async): state=IDLE; line addr, beat cnt, err, abort flags = 0; every output 0; PERF_MISSES=0.
//  States: IDLE, REQ, FILL, DONE.
//  IDLE: FE_ICACHE_R = FE_REQ & IC_HIT (combinational). If FE_REQ & !IC_HIT & !FE_FLUSH: latch line = {FE_PC[63:OB],0},
//   clear cnt/err/abort, PERF_MISSES++ (saturating), -> REQ. FE_FLUSH same cycle as miss: no miss started.
//   MEM_RVALID in IDLE is ignored (no IC_WE).
//  REQ: MEM_REQ=1, MEM_ADDR=line, both stable until MEM_ACK; request never withdrawn, even on FE_FLUSH.
//   On MEM_ACK -> FILL. First beat is legal no earlier than the cycle after ACK; RVALID in REQ is ignored.
//  FILL: per MEM_RVALID: IC_WE=1, IC_WDATA=MEM_RDATA, IC_WADDR={line[63:OB],cnt,2'b00}, cnt++ (wraps to 0 after last),
//   err |= MEM_ERR. Last beat (cnt==LINE_WORDS-1): IC_LINE_VALID = !(err|MEM_ERR) same cycle, -> DONE.
//   Gaps between beats are allowed, no timeout.
//  DONE: 1 cycle. FE_IAF = err & !abort. -> IDLE. Array is stable, so the re-lookup in IDLE hits.
//  FE_ICACHE_R is 0 in REQ, FILL and DONE regardless of IC_HIT.
//  FE_FLUSH in REQ/FILL/DONE: sets abort (sticky until next miss). The fill still completes: memory data is correct,
//   so words are written and the line is validated unless err. abort only suppresses FE_IAF.
//  Error line: words are written but IC_LINE_VALID stays 0, so the line remains invalid. Fault is reported once, in DONE.
//  Latency: miss seen cycle N -> MEM_REQ cycle N+1; last beat cycle M -> DONE M+1 -> IDLE/FE_ICACHE_R earliest M+2.
//  Reset mid-fill: immediate return to IDLE and outputs 0. Beats arriving after release are ignored. Line is not validated.
// TESTING
//  1 Hit: IDLE, FE_REQ=1, IC_HIT=1, FE_PC=0x2000 -> FE_ICACHE_R=1 same cycle; MEM_REQ=0; PERF_MISSES=0.
//  2 Miss: FE_PC=0x1008, IC_HIT=0 -> next cycle MEM_REQ=1, MEM_ADDR=0x1000, held 3 cycles until ACK. Beats D0..D3 ->
//    IC_WADDR 0x1000/04/08/0C, IC_LINE_VALID on D3. FE_ICACHE_R=1 two cycles later with IC_HIT=1; PERF_MISSES=1.
//  3 Error: MEM_ERR on beat 2 of 4 -> all 4 IC_WE, IC_LINE_VALID=0, FE_IAF=1 for exactly the DONE cycle.
//  4 Flush+error: FE_FLUSH after beat 1, MEM_ERR on beat 3 -> fill completes, no IC_LINE_VALID, FE_IAF never asserted.
//  5 Flush at miss: FE_FLUSH=1 with FE_REQ=1, IC_HIT=0 in IDLE -> MEM_REQ stays 0, PERF_MISSES unchanged.
//  6 Reset mid-fill after beat 2: RESET=0 -> BUSY/MEM_REQ/IC_WE=0 asynchronously. After release, stray RVALID -> no IC_WE.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Miss/refill sequencer for the fetch-stage instruction cache: detects misses, requests a line
// from memory, streams returned words into the array and validates the line or raises a fault.
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [63:0]      FE_PC,
    input  logic             FE_REQ,
    input  logic             FE_FLUSH,
    input  logic             IC_HIT,
    output logic             FE_ICACHE_R,
    output logic             FE_IAF,
    output logic             MEM_REQ,
    output logic [63:0]      MEM_ADDR,
    input  logic             MEM_ACK,
    input  logic             MEM_RVALID,
    input  logic [31:0]      MEM_RDATA,
    input  logic             MEM_ERR,
    output logic             IC_WE,
    output logic [63:0]      IC_WADDR,
    output logic [31:0]      IC_WDATA,
    output logic             IC_LINE_VALID,
    output logic             BUSY,
    output logic [CNT_W-1:0] PERF_MISSES
);

    localparam int BW = $clog2(LINE_WORDS);
    localparam int OB = BW + 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        DONE
    } state_t;

    state_t             state;
    logic [63:0]        line_addr;
    logic [BW-1:0]      beat_cnt;
    logic               err;
    logic               abort;
    logic [CNT_W-1:0]   miss_cnt;

    logic               miss_start;
    logic               fill_beat;
    logic               last_beat;
    logic               pc_offset_unused;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign miss_start       = (state == IDLE) && FE_REQ && !IC_HIT && !FE_FLUSH;
    assign fill_beat        = (state == FILL) && MEM_RVALID;
    assign last_beat        = (beat_cnt == BW'(LINE_WORDS - 1));
    assign pc_offset_unused = ^FE_PC[OB-1:0];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            line_addr <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
            abort     <= 1'b0;
            miss_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_start) begin
                        line_addr <= {FE_PC[63:OB], {OB{1'b0}}};
                        beat_cnt  <= '0;
                        err       <= 1'b0;
                        abort     <= 1'b0;
                        miss_cnt  <= sat_inc(miss_cnt);
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // A redirect never withdraws the request; it only mutes the fault report.
                    abort <= abort | FE_FLUSH;
                    if (MEM_ACK) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    abort <= abort | FE_FLUSH;
                    if (MEM_RVALID) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        err      <= err | MEM_ERR;
                        if (last_beat) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    abort <= abort | FE_FLUSH;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Fetch may only see a hit while no refill is in flight; held low during reset.
    assign FE_ICACHE_R   = RESET && (state == IDLE) && FE_REQ && IC_HIT;
    assign FE_IAF        = (state == DONE) && err && !abort;
    assign MEM_REQ       = (state == REQ);
    assign MEM_ADDR      = line_addr;
    assign IC_WE         = fill_beat;
    assign IC_WADDR      = fill_beat ? {line_addr[63:OB], beat_cnt, 2'b00} : '0;
    assign IC_WDATA      = fill_beat ? MEM_RDATA : '0;
    assign IC_LINE_VALID = fill_beat && last_beat && !(err || MEM_ERR);
    assign BUSY          = (state != IDLE);
    assign PERF_MISSES   = miss_cnt;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized self-checking bench for icache_refill_ctrl; each miss is modelled as a transaction
// whose expected addresses, data, validation and fault outcome are derived arithmetically.
module tb_icache_refill_ctrl;

    localparam int LW = 4;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [63:0]   FE_PC;
    logic          FE_REQ, FE_FLUSH, IC_HIT;
    logic          FE_ICACHE_R, FE_IAF, MEM_REQ;
    logic [63:0]   MEM_ADDR;
    logic          MEM_ACK, MEM_RVALID, MEM_ERR;
    logic [31:0]   MEM_RDATA;
    logic          IC_WE, IC_LINE_VALID, BUSY;
    logic [63:0]   IC_WADDR;
    logic [31:0]   IC_WDATA;
    logic [CW-1:0] PERF_MISSES;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_miss = '0;

    always #5 CLK = ~CLK;

    icache_refill_ctrl #(.LINE_WORDS(LW), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .FE_PC(FE_PC), .FE_REQ(FE_REQ), .FE_FLUSH(FE_FLUSH),
        .IC_HIT(IC_HIT), .FE_ICACHE_R(FE_ICACHE_R), .FE_IAF(FE_IAF), .MEM_REQ(MEM_REQ),
        .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
        .MEM_ERR(MEM_ERR), .IC_WE(IC_WE), .IC_WADDR(IC_WADDR), .IC_WDATA(IC_WDATA),
        .IC_LINE_VALID(IC_LINE_VALID), .BUSY(BUSY), .PERF_MISSES(PERF_MISSES)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet_inputs();
        FE_REQ = 1'b0; IC_HIT = 1'b0; FE_FLUSH = 1'b0; MEM_ACK = 1'b0;
        MEM_RVALID = 1'b0; MEM_ERR = 1'b0; MEM_RDATA = '0;
    endtask

    function automatic logic [CW-1:0] miss_after(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    // One complete miss transaction from the detecting cycle to the first hit afterwards.
    task automatic do_miss(input logic [63:0] pc, input int ack_dly, input logic [LW-1:0] err_mask,
                           input int flush_beat, input int max_gap, input bit rnd_flush);
        logic [63:0] line;
        logic [31:0] wd;
        bit          flushed;
        bit          anyerr;
        line    = pc & ~64'(LW * 4 - 1);
        flushed = 1'b0;
        anyerr  = 1'b0;
        FE_PC = pc; FE_REQ = 1'b1; IC_HIT = 1'b0; FE_FLUSH = 1'b0; MEM_RVALID = 1'b0; MEM_ACK = 1'b0;
        settle();
        chk("miss_r", 64'(FE_ICACHE_R), 64'd0);
        chk("miss_busy", 64'(BUSY), 64'd0);
        exp_miss = miss_after(exp_miss);
        adv();
        for (int i = 0; i <= ack_dly; i++) begin
            MEM_ACK = (i == ack_dly); FE_REQ = 1'($urandom); IC_HIT = 1'($urandom);
            MEM_RVALID = 1'($urandom); MEM_ERR = 1'($urandom); MEM_RDATA = $urandom;
            FE_FLUSH = rnd_flush && ($urandom_range(0, 3) == 0);
            flushed |= FE_FLUSH;
            settle();
            chk("req_memreq", 64'(MEM_REQ), 64'd1);
            chk("req_addr", MEM_ADDR, line);
            chk("req_we", 64'(IC_WE), 64'd0);
            chk("req_r", 64'(FE_ICACHE_R), 64'd0);
            adv();
        end
        MEM_ACK = 1'b0;
        for (int b = 0; b < LW; b++) begin
            int gap;
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                MEM_RVALID = 1'b0; MEM_ERR = 1'($urandom); FE_REQ = 1'($urandom); IC_HIT = 1'($urandom);
                FE_FLUSH = rnd_flush && ($urandom_range(0, 3) == 0);
                flushed |= FE_FLUSH;
                settle();
                chk("gap_we", 64'(IC_WE), 64'd0);
                chk("gap_memreq", 64'(MEM_REQ), 64'd0);
                chk("gap_r", 64'(FE_ICACHE_R), 64'd0);
                adv();
            end
            wd = $urandom;
            MEM_RVALID = 1'b1; MEM_RDATA = wd; MEM_ERR = err_mask[b];
            anyerr |= err_mask[b];
            FE_FLUSH = (b == flush_beat) || (rnd_flush && ($urandom_range(0, 3) == 0));
            flushed |= FE_FLUSH;
            settle();
            chk("beat_we", 64'(IC_WE), 64'd1);
            chk("beat_waddr", IC_WADDR, line + 64'(4 * b));
            chk("beat_wdata", 64'(IC_WDATA), 64'(wd));
            chk("beat_lv", 64'(IC_LINE_VALID), 64'((b == LW - 1) && !anyerr));
            chk("beat_r", 64'(FE_ICACHE_R), 64'd0);
            adv();
        end
        MEM_RVALID = 1'b0; MEM_ERR = 1'b0; FE_FLUSH = 1'b0; FE_REQ = 1'b1; IC_HIT = 1'b1;
        settle();
        chk("done_iaf", 64'(FE_IAF), 64'(anyerr && !flushed));
        chk("done_r", 64'(FE_ICACHE_R), 64'd0);
        chk("done_busy", 64'(BUSY), 64'd1);
        adv();
        settle();
        chk("after_r", 64'(FE_ICACHE_R), 64'd1);
        chk("after_iaf", 64'(FE_IAF), 64'd0);
        chk("after_busy", 64'(BUSY), 64'd0);
        chk("after_misses", 64'(PERF_MISSES), 64'(exp_miss));
        adv();
    endtask

    task automatic hit_cycle(input logic [63:0] pc);
        FE_PC = pc; FE_REQ = 1'b1; IC_HIT = 1'b1; FE_FLUSH = 1'b0; MEM_RVALID = 1'b0;
        settle();
        chk("hit_r", 64'(FE_ICACHE_R), 64'd1);
        chk("hit_memreq", 64'(MEM_REQ), 64'd0);
        chk("hit_misses", 64'(PERF_MISSES), 64'(exp_miss));
        adv();
    endtask

    task automatic flush_miss_cycle(input logic [63:0] pc);
        FE_PC = pc; FE_REQ = 1'b1; IC_HIT = 1'b0; FE_FLUSH = 1'b1;
        settle();
        chk("fmiss_r", 64'(FE_ICACHE_R), 64'd0);
        adv();
        quiet_inputs();
        settle();
        chk("fmiss_memreq", 64'(MEM_REQ), 64'd0);
        chk("fmiss_busy", 64'(BUSY), 64'd0);
        chk("fmiss_misses", 64'(PERF_MISSES), 64'(exp_miss));
        adv();
    endtask

    task automatic stray_beat();
        quiet_inputs();
        MEM_RVALID = 1'b1; MEM_RDATA = $urandom; MEM_ERR = 1'($urandom);
        settle();
        chk("stray_we", 64'(IC_WE), 64'd0);
        chk("stray_lv", 64'(IC_LINE_VALID), 64'd0);
        chk("stray_busy", 64'(BUSY), 64'd0);
        adv();
    endtask

    initial begin
        RESET = 1'b0;
        FE_PC = 64'h2000;
        quiet_inputs();
        FE_REQ = 1'b1; IC_HIT = 1'b1;
        #2;
        chk("rst_r", 64'(FE_ICACHE_R), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_memreq", 64'(MEM_REQ), 64'd0);
        chk("rst_addr", MEM_ADDR, 64'd0);
        chk("rst_misses", 64'(PERF_MISSES), 64'd0);
        adv();
        adv();
        RESET = 1'b1;
        quiet_inputs();

        hit_cycle(64'h2000);
        do_miss(64'h1008, 2, 4'b0000, -1, 0, 1'b0);
        do_miss(64'h3004, 1, 4'b0010, -1, 0, 1'b0);
        do_miss(64'h4010, 0, 4'b0100, 1, 1, 1'b0);
        flush_miss_cycle(64'h5000);

        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                hit_cycle({$urandom, $urandom});
            end else if (sel == 2) begin
                stray_beat();
            end else if (sel == 3) begin
                flush_miss_cycle({$urandom, $urandom});
            end else begin
                logic [LW-1:0] em;
                em = ($urandom_range(0, 2) == 0) ? LW'($urandom) : '0;
                do_miss({$urandom, $urandom}, $urandom_range(0, 3), em, -1, 2, 1'($urandom));
            end
        end

        // Reset in the middle of a fill, after two beats.
        FE_PC = 64'h6000; FE_REQ = 1'b1; IC_HIT = 1'b0; FE_FLUSH = 1'b0;
        adv();
        FE_REQ = 1'b0; MEM_ACK = 1'b1;
        adv();
        MEM_ACK = 1'b0; MEM_RVALID = 1'b1; MEM_RDATA = 32'h1111_0000;
        adv();
        adv();
        MEM_RDATA = 32'h2222_0000;
        #2;
        chk("prerst_busy", 64'(BUSY), 64'd1);
        RESET = 1'b0;
        #1;
        chk("midrst_busy", 64'(BUSY), 64'd0);
        chk("midrst_memreq", 64'(MEM_REQ), 64'd0);
        chk("midrst_we", 64'(IC_WE), 64'd0);
        chk("midrst_lv", 64'(IC_LINE_VALID), 64'd0);
        chk("midrst_misses", 64'(PERF_MISSES), 64'd0);
        exp_miss = '0;
        adv();
        RESET = 1'b1;
        stray_beat();
        stray_beat();
        hit_cycle(64'h6000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
